// File: rtl/final_layer_streamed.sv
// Streamed binary classifier output layer.
// Feature bits arrive in CHUNK_WIDTH-bit chunks; every class accumulates an
// XNOR-popcount score against its weight chunk. After the last chunk a
// one-class-per-cycle argmax scan picks the winner (ties go to the lowest
// index) and the result is offered on a valid/ready handshake.
module final_layer_streamed #(
    parameter int NUM_INPUTS  = 196,
    parameter int NUM_CLASSES = 10,
    parameter int CHUNK_WIDTH = 28,
    localparam int K     = NUM_INPUTS / CHUNK_WIDTH,
    localparam int CNT_W = $clog2(NUM_INPUTS + 1),
    localparam int IDX_W = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               en,
    input  logic                               start,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [CHUNK_WIDTH-1:0]             data_in,
    input  logic [NUM_CLASSES*CHUNK_WIDTH-1:0] weights_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [IDX_W-1:0]                   answer,
    output logic [CNT_W-1:0]                   score,
    output logic                               busy
);

    localparam int KCW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_ARGMAX = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    logic [CNT_W-1:0]   acc_r      [NUM_CLASSES];
    logic [CNT_W-1:0]   acc_nxt_s  [NUM_CLASSES];
    logic [KCW-1:0]     chunk_cnt_r;
    logic [IDX_W-1:0]   scan_idx_r;
    logic [CNT_W-1:0]   best_val_r;
    logic [IDX_W-1:0]   best_idx_r;
    logic [CNT_W-1:0]   upd_val_s;
    logic [IDX_W-1:0]   upd_idx_s;
    logic [IDX_W-1:0]   answer_r;
    logic [CNT_W-1:0]   score_r;
    logic               last_chunk_s;
    logic               last_scan_s;

    // Number of matching bit positions between a data chunk and a weight chunk.
    function automatic logic [CNT_W-1:0] xnor_popcount(
        input logic [CHUNK_WIDTH-1:0] d,
        input logic [CHUNK_WIDTH-1:0] w
    );
        logic [CNT_W-1:0] n;
        logic             b;
        n = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            b = d[i] ~^ w[i];
            n = n + CNT_W'(b);
        end
        return n;
    endfunction

    assign last_chunk_s = (chunk_cnt_r == KCW'(K - 1));
    assign last_scan_s  = (scan_idx_r == IDX_W'(NUM_CLASSES - 1));

    // Per-class accumulator values after the current chunk is absorbed.
    always_comb begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
            acc_nxt_s[c] = acc_r[c] + xnor_popcount(data_in, weights_in[c*CHUNK_WIDTH +: CHUNK_WIDTH]);
        end
    end

    // Argmax step: strictly greater replaces the best, so ties keep the lower index.
    always_comb begin
        upd_val_s = best_val_r;
        upd_idx_s = best_idx_r;
        if (acc_r[scan_idx_r] > best_val_r) begin
            upd_val_s = acc_r[scan_idx_r];
            upd_idx_s = scan_idx_r;
        end else begin
            upd_val_s = best_val_r;
            upd_idx_s = best_idx_r;
        end
    end

    // Next-state logic; a low enable forces the FSM back to idle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_ACCUM;
                else       next_state_s = ST_IDLE;
            end
            ST_ACCUM: begin
                if (in_valid && last_chunk_s) next_state_s = ST_ARGMAX;
                else                          next_state_s = ST_ACCUM;
            end
            ST_ARGMAX: begin
                if (last_scan_s) next_state_s = ST_RESULT;
                else             next_state_s = ST_ARGMAX;
            end
            ST_RESULT: begin
                if (out_ready) next_state_s = ST_IDLE;
                else           next_state_s = ST_RESULT;
            end
            default: next_state_s = ST_IDLE;
        endcase
        if (!en) begin
            next_state_s = ST_IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // State register plus registered status flags decoded from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s == ST_ACCUM);
            out_valid_r <= (next_state_s == ST_RESULT);
            busy_r      <= (next_state_s != ST_IDLE);
        end
    end

    // Accumulation, argmax scan and result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CLASSES; c++) acc_r[c] <= '0;
            chunk_cnt_r <= '0;
            scan_idx_r  <= '0;
            best_val_r  <= '0;
            best_idx_r  <= '0;
            answer_r    <= '0;
            score_r     <= '0;
        end else if (!en) begin
            // Abort: drop the image in flight but keep the last published result.
            for (int c = 0; c < NUM_CLASSES; c++) acc_r[c] <= '0;
            chunk_cnt_r <= '0;
            scan_idx_r  <= '0;
            best_val_r  <= '0;
            best_idx_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        for (int c = 0; c < NUM_CLASSES; c++) acc_r[c] <= '0;
                        chunk_cnt_r <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        for (int c = 0; c < NUM_CLASSES; c++) acc_r[c] <= acc_nxt_s[c];
                        chunk_cnt_r <= chunk_cnt_r + KCW'(1);
                        if (last_chunk_s) begin
                            best_val_r <= acc_nxt_s[0];
                            best_idx_r <= '0;
                            scan_idx_r <= IDX_W'(1);
                        end
                    end
                end
                ST_ARGMAX: begin
                    best_val_r <= upd_val_s;
                    best_idx_r <= upd_idx_s;
                    scan_idx_r <= scan_idx_r + IDX_W'(1);
                    if (last_scan_s) begin
                        answer_r <= upd_idx_s;
                        score_r  <= upd_val_s;
                    end
                end
                ST_RESULT: begin
                    chunk_cnt_r <= chunk_cnt_r;
                end
                default: begin
                    chunk_cnt_r <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign answer    = answer_r;
    assign score     = score_r;

endmodule

// File: tb/tb_final_layer_streamed.sv
// Scoreboard bench for final_layer_streamed: stimulus pushes the reference
// model's answer/score into a queue, a negedge monitor pops and compares.
module tb_final_layer_streamed;

    localparam int NI    = 196;
    localparam int NC    = 10;
    localparam int CW    = 28;
    localparam int K     = NI / CW;
    localparam int CNT_W = $clog2(NI + 1);
    localparam int IDX_W = $clog2(NC);

    typedef logic [NI-1:0] vec_t;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  en = 1'b0;
    logic                  start = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [CW-1:0]         data_in = '0;
    logic [NC*CW-1:0]      weights_in = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [IDX_W-1:0]      answer;
    logic [CNT_W-1:0]      score;
    logic                  busy;

    int   vectors = 0;
    int   miscompares = 0;
    vec_t data_v;
    vec_t w_v [NC];
    int   exp_ans_q [$];
    int   exp_sc_q  [$];
    int   last_ans = 0;
    int   last_sc  = 0;
    bit   have_cur = 1'b0;
    int   cur_ans  = 0;
    int   cur_sc   = 0;

    final_layer_streamed #(.NUM_INPUTS(NI), .NUM_CLASSES(NC), .CHUNK_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .en(en), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .weights_in(weights_in), .out_valid(out_valid), .out_ready(out_ready),
        .answer(answer), .score(score), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < NI; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic vec_t low_mask(input int n);
        vec_t m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Reference: score = number of equal bits over the full image; first maximum wins.
    task automatic expect_image();
        int best, ans, s;
        best = -1;
        ans  = 0;
        for (int c = 0; c < NC; c++) begin
            s = NI - $countones(data_v ^ w_v[c]);
            if (s > best) begin
                best = s;
                ans  = c;
            end
        end
        exp_ans_q.push_back(ans);
        exp_sc_q.push_back(best);
        last_ans = ans;
        last_sc  = best;
    endtask

    // Start an image and feed n_chunks chunks with 'gap' idle cycles before each.
    task automatic drive_image(input int gap, input int n_chunks);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("in_ready_in_accum", int'(in_ready), 1);
        for (int k = 0; k < n_chunks; k++) begin
            repeat (gap) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            data_in  = data_v[k*CW +: CW];
            for (int c = 0; c < NC; c++) weights_in[c*CW +: CW] = w_v[c][k*CW +: CW];
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Wait for the result, hold out_ready low 'hold' cycles, then take it.
    task automatic collect(input int hold, input int exp_lat);
        int cycles;
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            tick();
            cycles++;
        end
        if (!out_valid) begin
            chk("result_timeout", 0, 1);
        end else begin
            if (exp_lat >= 0) chk("latency_after_last_chunk", cycles, exp_lat);
            repeat (hold) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("out_valid_after_handshake", int'(out_valid), 0);
            chk("busy_after_handshake", int'(busy), 0);
        end
    endtask

    // Monitor: pop the expected result when out_valid first appears, then check stability.
    always @(negedge clock) begin
        if (out_valid) begin
            if (!have_cur) begin
                if (exp_ans_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: got answer %0d score %0d, expected none", answer, score);
                end else begin
                    cur_ans = exp_ans_q.pop_front();
                    cur_sc  = exp_sc_q.pop_front();
                    chk("answer", int'(answer), cur_ans);
                    chk("score", int'(score), cur_sc);
                end
                have_cur = 1'b1;
            end else begin
                chk("answer_stable", int'(answer), cur_ans);
                chk("score_stable", int'(score), cur_sc);
            end
            if (out_ready) have_cur = 1'b0;
        end
    end

    initial begin
        int seen;
        repeat (3) tick();
        chk("reset_answer", int'(answer), 0);
        chk("reset_score", int'(score), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b1;
        en    = 1'b1;
        tick();

        // Class 3 matches exactly, all others fully inverted.
        data_v = rand_vec();
        for (int c = 0; c < NC; c++) w_v[c] = (c == 3) ? data_v : ~data_v;
        expect_image();
        drive_image(0, K);
        collect(0, NC - 1);

        // Classes 2 and 7 tie at 150; lowest index must win.
        data_v = rand_vec();
        for (int c = 0; c < NC; c++)
            w_v[c] = data_v ^ low_mask((c == 2 || c == 7) ? 46 : 47 + c);
        expect_image();
        drive_image(0, K);
        collect(0, NC - 1);

        // All-zero scores still produce a result.
        data_v = rand_vec();
        for (int c = 0; c < NC; c++) w_v[c] = ~data_v;
        expect_image();
        drive_image(0, K);
        collect(0, NC - 1);

        // Gaps of 3 cycles between chunks, consumer stalls 5 cycles.
        data_v = rand_vec();
        for (int c = 0; c < NC; c++) w_v[c] = rand_vec();
        expect_image();
        drive_image(3, K);
        collect(5, NC - 1);

        // Asynchronous reset after 4 chunks.
        data_v = rand_vec();
        for (int c = 0; c < NC; c++) w_v[c] = rand_vec();
        drive_image(0, 4);
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_answer", int'(answer), 0);
        chk("midreset_score", int'(score), 0);
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_in_ready", int'(in_ready), 0);
        chk("midreset_busy", int'(busy), 0);
        tick();
        reset = 1'b1;
        tick();
        data_v = rand_vec();
        for (int c = 0; c < NC; c++) w_v[c] = data_v ^ low_mask(5 * c + 1);
        expect_image();
        drive_image(0, K);
        collect(2, NC - 1);

        // en dropped for one cycle during the argmax scan.
        data_v = rand_vec();
        for (int c = 0; c < NC; c++) w_v[c] = (c == 9) ? data_v : rand_vec();
        drive_image(0, K);
        repeat (3) tick();
        en = 1'b0;
        tick();
        en = 1'b1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_answer_kept", int'(answer), last_ans);
        chk("abort_score_kept", int'(score), last_sc);
        seen = 0;
        repeat (12) begin
            if (out_valid) seen++;
            tick();
        end
        chk("no_result_after_abort", seen, 0);
        data_v = rand_vec();
        for (int c = 0; c < NC; c++) w_v[c] = rand_vec();
        expect_image();
        drive_image(1, K);
        collect(1, NC - 1);

        // Random images with random gaps and consumer stalls.
        for (int n = 0; n < 6; n++) begin
            data_v = rand_vec();
            for (int c = 0; c < NC; c++) w_v[c] = rand_vec();
            expect_image();
            drive_image(int'($urandom_range(0, 2)), K);
            collect(int'($urandom_range(0, 4)), -1);
        end

        repeat (3) tick();
        chk("scoreboard_drained", exp_ans_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/final_layer_streamed.md
# final_layer_streamed

Parametrised, sequential successor to the single-cycle final classifier layer of the binary MNIST network. Binarised feature bits arrive in fixed-width chunks over a valid/ready handshake. For every class, the block accumulates an XNOR-popcount score against the matching weight chunk. After the last chunk, a multi-cycle argmax scan picks the winning class, and the block returns the class index and its score over a valid/ready result handshake.

## Interface
- NUM_INPUTS, 196: total input bits per image; must be a multiple of CHUNK_WIDTH.
- NUM_CLASSES, 10: number of output neurons; must be at least 2.
- CHUNK_WIDTH, 28: input bits consumed per accepted transfer.
- Derived constants:
  - K = NUM_INPUTS/CHUNK_WIDTH.
  - CNT_W = $clog2(NUM_INPUTS+1).
  - IDX_W = max(1, $clog2(NUM_CLASSES)).
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  synchronous enable; low aborts the current image (see Operation).
- start  in  1  begin a new image; sampled only in IDLE with en=1.
- in_valid  in  1  data_in/weights_in hold a valid chunk.
- in_ready  out  1  block accepts a chunk this cycle.
- data_in  in  CHUNK_WIDTH  feature-bit chunk.
- weights_in  in  NUM_CLASSES x CHUNK_WIDTH  weight chunk per class, aligned to data_in.
- out_valid  out  1  answer/score hold a new result.
- out_ready  in  1  consumer takes the result.
- answer  out  IDX_W  winning class index; registered.
- score  out  CNT_W  popcount of the winning class; registered.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCUM, ARGMAX, RESULT.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1 and en=1: clear all NUM_CLASSES accumulators and chunk_cnt, then go to ACCUM.
- ACCUM:
  - in_ready=1.
  - Each handshake (in_valid and in_ready): acc[c] += popcount(weights_in[c] XNOR data_in) for every c; chunk_cnt++.
  - in_valid=0 stalls with no state change. Gaps are unlimited.
  - The handshake with chunk_cnt=K-1 moves to ARGMAX with best_val=acc[0] (post-update), best_idx=0, scan_idx=1.
- ARGMAX:
  - One class per cycle: if acc[scan_idx] > best_val (strictly greater), then best_val/best_idx take acc[scan_idx]/scan_idx.
  - scan_idx++. After scan_idx=NUM_CLASSES-1 is processed, load answer=best_idx, score=best_val, and go to RESULT.
  - Ties resolve to the lowest index.
- RESULT:
  - out_valid=1; answer/score held stable.
  - On out_ready=1: go to IDLE.
  - answer/score keep their value until the next RESULT load.
- start outside IDLE is ignored.
- Accumulators are CNT_W wide and cannot overflow, since the maximum value is NUM_INPUTS.
- An all-zero score set is a valid result: answer=0, score=0, out_valid asserted normally.
- en=0 in any state, at the next edge:
  - state goes to IDLE; accumulators, chunk_cnt and scan state are cleared; out_valid=0.
  - answer/score keep their last value.
  - A handshake coinciding with en=0 is discarded.
- reset low, asynchronously: state IDLE, accumulators 0, chunk_cnt 0, answer 0, score 0, out_valid 0, in_ready 0, busy 0. This holds even mid-ACCUM or mid-ARGMAX.

## Timing
- Edge E0 samples start.
- Chunks can be accepted on E1..EK back-to-back.
- ARGMAX occupies edges EK+1..EK+NUM_CLASSES-1.
- out_valid is high from edge EK+NUM_CLASSES-1 onward. With defaults this is E16.
- Minimum start-to-out_valid latency is K+NUM_CLASSES-1 cycles. Each in_valid stall cycle adds one.
- in_ready is a pure function of state, with no combinational path from in_valid.
- out_valid is registered.
- Throughput:
  - The result handshake at edge Ei returns the block to IDLE.
  - start is sampled no earlier than edge Ei+1.
  - With defaults this gives one image per at least 18 cycles.
- busy, in_ready and out_valid change only on clock edges, or asynchronously on reset.

## Test plan
- Class 3 weights equal data for all chunks; other classes weights = ~data; chunks back-to-back -> out_valid at E16, answer=3, score=196, busy low after the out_ready handshake.
- Classes 2 and 7 both score 150; all others score less than 150 -> answer=2, score=150 (lowest-index tie rule).
- All classes use weights = ~data -> answer=0, score=0, out_valid=1 (zero result still reported).
- Random in_valid gaps: 3 idle cycles between each chunk; out_ready held low 5 cycles in RESULT -> scores match a reference model; answer/score stable while waiting; out_valid drops the edge after out_ready=1.
- reset pulsed low after 4 chunks accepted -> all outputs zero immediately. A fresh start then gives a result unaffected by the aborted image.
- en=0 for one cycle during ARGMAX, then start again -> no out_valid for the aborted image; the new image gives the correct result; answer/score retain the prior image's values until the new RESULT.
